fifo_wr_arbiter: RTL and testbench

//   Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ requesters.

---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write arbiter sharing one synchronous FIFO write port among
// NUM_REQ requesters. A winner keeps the port for one burst, which ends on an
// accepted req_last beat or after MAX_BURST accepted beats. The winner then
// drops to lowest priority. Data is muxed straight onto the FIFO write port,
// and fifo_full stalls the burst without losing or repeating a beat.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  input  logic                      fifo_full
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Beat count at which the next accepted beat closes the burst.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;    // highest-priority requester for the next arbitration
  logic [IDX_W-1:0]    g_idx;     // binary index of the current grant, used for muxing
  logic [CNT_W-1:0]    beat_cnt;  // beats accepted so far in the current burst

  logic [DATA_W-1:0]   req_word [NUM_REQ];
  logic                any_valid;
  logic [IDX_W-1:0]    winner;
  logic                accept;
  logic                burst_done;

  // Wrap-around increment of a requester index.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Unpack the flat requester data bus into one word per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    any_valid = |req_valid;
    winner    = rr_ptr;
    cand      = rr_ptr;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
      cand = next_idx(cand);
    end
  end

  // Port mux: only the granted requester sees ready and reaches the FIFO.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (state == BURST) begin
      req_ready    = fifo_full ? '0 : grant;
      fifo_wr_en   = req_valid[g_idx] & ~fifo_full;
      fifo_wr_data = req_word[g_idx];
    end
  end

  // A beat is accepted exactly when it is written into the FIFO.
  assign accept     = fifo_wr_en;
  assign burst_done = accept & (req_last[g_idx] | (beat_cnt == LAST_CNT));

  // Arbitration FSM; grant and busy are registered with the state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values and update order inside the block is irrelevant.
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      g_idx    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state    <= BURST;
            grant    <= onehot(winner);
            busy     <= 1'b1;
            g_idx    <= winner;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (burst_done) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            rr_ptr   <= next_idx(g_idx);
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the arbiter.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_busy_matches  : assert property (@(posedge clk) disable iff (rst) busy == (grant != '0));
  a_no_write_full : assert property (@(posedge clk) disable iff (rst) fifo_full |-> !fifo_wr_en);
  a_cnt_in_range  : assert property (@(posedge clk) disable iff (rst) beat_cnt <= LAST_CNT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios checked against
// hand-derived values, plus a random run checked against a cycle-level
// behavioural model and a write-stream scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
  logic           fifo_full;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: owner of the port (-1 when idle), beats taken, priority start.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;

  logic [N-1:0] e_grant;
  logic [N-1:0] e_ready;
  logic         e_wen;
  logic         e_busy;
  logic [W-1:0] e_data;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .busy         (busy),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current model state and current inputs.
  task automatic predict();
    e_grant = '0;
    e_ready = '0;
    e_wen   = 1'b0;
    e_busy  = 1'b0;
    e_data  = '0;
    if (m_owner >= 0) begin
      e_grant = N'(1) << m_owner;
      e_busy  = 1'b1;
      e_ready = fifo_full ? '0 : e_grant;
      e_wen   = req_valid[m_owner] && !fifo_full;
      e_data  = req_data[m_owner*W +: W];
    end
  endtask

  // Apply the clock edge to the model, then move to the next negedge.
  task automatic advance();
    predict();
    if (rst) begin
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
          break;
        end
      end
    end else if (e_wen) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [W-1:0] d);
    req_valid[i]       = v;
    req_last[i]        = l;
    req_data[i*W +: W] = d;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_last  = '1;
    req_data  = '1;
    fifo_full = 1'b0;
    advance();
    advance();
    #1;
    n_checks++; if (grant !== '0)        begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (req_ready !== '0)    begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_checks++; if (fifo_wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", fifo_wr_data); end
    rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    advance();
  endtask

  task automatic test_single_burst();
    logic [W-1:0] beats [3];
    logic [N-1:0] exp_g;
    logic         exp_w;
    int           b;
    beats = '{8'hA0, 8'hA1, 8'hA2};
    b     = 0;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      if (b < 3) set_req(2, 1'b1, (b == 2), beats[b]);
      else       set_req(2, 1'b0, 1'b0, '0);
      #1;
      predict();
      exp_g = (c >= 1 && c <= 3) ? 4'b0100 : 4'b0000;
      exp_w = (c >= 1 && c <= 3);
      n_checks++; if (grant !== exp_g)      begin n_fail++; $display("FAIL single_grant c=%0d: got %b want %b", c, grant, exp_g); end
      n_checks++; if (busy !== exp_w)       begin n_fail++; $display("FAIL single_busy c=%0d: got %b want %b", c, busy, exp_w); end
      n_checks++; if (fifo_wr_en !== exp_w) begin n_fail++; $display("FAIL single_wr_en c=%0d: got %b want %b", c, fifo_wr_en, exp_w); end
      if (exp_w) begin
        n_checks++; if (fifo_wr_data !== beats[c-1]) begin n_fail++; $display("FAIL single_data c=%0d: got %h want %h", c, fifo_wr_data, beats[c-1]); end
      end
      if (e_wen) b++;
      advance();
    end
    // Priority now starts at requester 3, so it beats requester 1.
    set_req(1, 1'b1, 1'b1, 8'h11);
    set_req(3, 1'b1, 1'b1, 8'h33);
    advance();
    #1;
    n_checks++; if (grant !== 4'b1000)      begin n_fail++; $display("FAIL single_rr_ptr: got %b want 1000", grant); end
    n_checks++; if (fifo_wr_data !== 8'h33) begin n_fail++; $display("FAIL single_rr_data: got %h want 33", fifo_wr_data); end
    advance();
    set_req(1, 1'b0, 1'b0, '0);
    set_req(3, 1'b0, 1'b0, '0);
    advance();
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g;
    int           idx;
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, W'(8'h10 + i));
    for (int c = 0; c < 10; c++) begin
      #1;
      idx   = (c / 2) % N;
      exp_g = (c % 2 == 1) ? (N'(1) << idx) : '0;
      n_checks++; if (grant !== exp_g)   begin n_fail++; $display("FAIL cont_grant c=%0d: got %b want %b", c, grant, exp_g); end
      n_checks++; if (!$onehot0(grant))  begin n_fail++; $display("FAIL cont_onehot c=%0d: got %b want one-hot or zero", c, grant); end
      if (c % 2 == 1) begin
        n_checks++; if (fifo_wr_data !== W'(8'h10 + idx)) begin n_fail++; $display("FAIL cont_data c=%0d: got %h want %h", c, fifo_wr_data, W'(8'h10 + idx)); end
      end
      advance();
    end
    req_valid = '0;
    advance();
  endtask

  task automatic test_max_burst();
    int k1;
    int n1;
    logic r2;
    k1 = 0;
    n1 = 0;
    r2 = 1'b1;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      set_req(1, (k1 < 10), (k1 == 9), W'(8'h20 + k1));
      set_req(2, r2, 1'b1, 8'h55);
      #1;
      predict();
      if (c >= 1 && c <= 8) begin
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL maxb_grant c=%0d: got %b want 0010", c, grant); end
        n_checks++; if (fifo_wr_data !== W'(8'h20 + c - 1)) begin n_fail++; $display("FAIL maxb_data c=%0d: got %h want %h", c, fifo_wr_data, W'(8'h20 + c - 1)); end
      end
      if (c == 9 || c == 11) begin
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL maxb_idle c=%0d: got %b want 0000", c, grant); end
      end
      if (c == 10) begin
        n_checks++; if (grant !== 4'b0100)      begin n_fail++; $display("FAIL maxb_req2: got %b want 0100", grant); end
        n_checks++; if (fifo_wr_data !== 8'h55) begin n_fail++; $display("FAIL maxb_req2_data: got %h want 55", fifo_wr_data); end
      end
      if (c == 12) begin
        n_checks++; if (grant !== 4'b0010)      begin n_fail++; $display("FAIL maxb_regrant: got %b want 0010", grant); end
        n_checks++; if (fifo_wr_data !== 8'h28) begin n_fail++; $display("FAIL maxb_regrant_data: got %h want 28", fifo_wr_data); end
      end
      if (c < 10 && fifo_wr_en === 1'b1 && grant === 4'b0010) n1++;
      if (e_wen && m_owner == 1) k1++;
      if (e_wen && m_owner == 2) r2 = 1'b0;
      advance();
    end
    n_checks++; if (n1 != MB) begin n_fail++; $display("FAIL maxb_count: got %0d beats want %0d", n1, MB); end
    req_valid = '0;
    advance();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got [$];
    int k;
    k = 0;
    apply_reset();
    for (int c = 0; c < 15; c++) begin
      set_req(0, (k < MB), 1'b0, W'(8'h30 + k));
      fifo_full = (c >= 3 && c <= 7);
      #1;
      predict();
      if (c >= 3 && c <= 7) begin
        n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL bp_wr_en c=%0d: got %b want 0", c, fifo_wr_en); end
        n_checks++; if (req_ready !== '0)    begin n_fail++; $display("FAIL bp_ready c=%0d: got %b want 0000", c, req_ready); end
        n_checks++; if (grant !== 4'b0001)   begin n_fail++; $display("FAIL bp_grant c=%0d: got %b want 0001", c, grant); end
      end
      if (c >= 8 && c <= 13) begin
        n_checks++; if (fifo_wr_en !== 1'b1)              begin n_fail++; $display("FAIL bp_resume c=%0d: got %b want 1", c, fifo_wr_en); end
        n_checks++; if (fifo_wr_data !== W'(8'h30 + c - 6)) begin n_fail++; $display("FAIL bp_resume_data c=%0d: got %h want %h", c, fifo_wr_data, W'(8'h30 + c - 6)); end
        n_checks++; if (grant !== 4'b0001)                begin n_fail++; $display("FAIL bp_hold c=%0d: got %b want 0001", c, grant); end
      end
      if (c == 14) begin
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL bp_end: got %b want 0000", grant); end
      end
      if (fifo_wr_en === 1'b1) got.push_back(fifo_wr_data);
      if (e_wen) k++;
      advance();
    end
    fifo_full = 1'b0;
    n_checks++; if (got.size() != MB) begin n_fail++; $display("FAIL bp_count: got %0d beats want %0d", got.size(), MB); end
    for (int i = 0; i < got.size() && i < MB; i++) begin
      n_checks++; if (got[i] !== W'(8'h30 + i)) begin n_fail++; $display("FAIL bp_stream[%0d]: got %h want %h", i, got[i], W'(8'h30 + i)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int nw;
    nw = 0;
    apply_reset();
    // A one-beat burst from requester 1 moves priority to requester 2.
    set_req(1, 1'b1, 1'b1, 8'h77);
    advance();
    advance();
    set_req(1, 1'b0, 1'b0, '0);
    advance();
    set_req(3, 1'b1, 1'b0, 8'h40);
    advance();
    #1;
    n_checks++; if (grant !== 4'b1000)      begin n_fail++; $display("FAIL rstmid_grant: got %b want 1000", grant); end
    n_checks++; if (fifo_wr_data !== 8'h40) begin n_fail++; $display("FAIL rstmid_beat0: got %h want 40", fifo_wr_data); end
    if (fifo_wr_en === 1'b1) nw++;
    advance();
    set_req(3, 1'b1, 1'b0, 8'h41);
    rst = 1'b1;
    #1;
    n_checks++; if (fifo_wr_data !== 8'h41) begin n_fail++; $display("FAIL rstmid_beat1: got %h want 41", fifo_wr_data); end
    if (fifo_wr_en === 1'b1) nw++;
    advance();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h0A);
    set_req(3, 1'b1, 1'b0, 8'h42);
    #1;
    n_checks++; if (grant !== '0)        begin n_fail++; $display("FAIL rstmid_idle_grant: got %b want 0000", grant); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstmid_idle_busy: got %b want 0", busy); end
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_wr_en: got %b want 0", fifo_wr_en); end
    n_checks++; if (req_ready !== '0)    begin n_fail++; $display("FAIL rstmid_idle_ready: got %b want 0000", req_ready); end
    if (fifo_wr_en === 1'b1) nw++;
    advance();
    #1;
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_rr_ptr: got %b want 0001", grant); end
    n_checks++; if (nw != 2)           begin n_fail++; $display("FAIL rstmid_written: got %0d beats want 2", nw); end
    advance();
  endtask

  task automatic test_random_scoreboard();
    logic [W-1:0] pd [N];
    logic         pl [N];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] act_q [$];
    int           run;
    run = 0;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      pd[i] = W'($urandom);
      pl[i] = ($urandom_range(0, 5) == 0);
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) set_req(i, ($urandom_range(0, 9) < 7), pl[i], pd[i]);
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      predict();
      n_checks++; if (grant !== e_grant)     begin n_fail++; $display("FAIL rand_grant cyc=%0d: got %b want %b", cyc, grant, e_grant); end
      n_checks++; if (busy !== e_busy)       begin n_fail++; $display("FAIL rand_busy cyc=%0d: got %b want %b", cyc, busy, e_busy); end
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, req_ready, e_ready); end
      n_checks++; if (fifo_wr_en !== e_wen)  begin n_fail++; $display("FAIL rand_wr_en cyc=%0d: got %b want %b", cyc, fifo_wr_en, e_wen); end
      n_checks++; if (fifo_wr_data !== e_data) begin n_fail++; $display("FAIL rand_data cyc=%0d: got %h want %h", cyc, fifo_wr_data, e_data); end
      if (grant === '0) run = 0;
      if (fifo_wr_en === 1'b1) begin
        act_q.push_back(fifo_wr_data);
        run++;
        n_checks++; if (run > MB) begin n_fail++; $display("FAIL rand_burst_len cyc=%0d: got %0d beats want <= %0d", cyc, run, MB); end
      end
      if (e_wen) begin
        exp_q.push_back(e_data);
        pd[m_owner] = W'($urandom);
        pl[m_owner] = ($urandom_range(0, 5) == 0);
      end
      advance();
    end
    fifo_full = 1'b0;
    n_checks++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_stream_len: got %0d writes want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_stream[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_contention();
    test_max_burst();
    test_backpressure();
    test_reset_mid_burst();
    test_random_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
